// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
// Also provides the rotating-priority pick helper.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MAX_BURST_DEFAULT = 4;
    localparam int NREQ = 4;

    // First set bit of req, scanning ptr, ptr+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(
        input logic [3:0] req,
        input logic [1:0] ptr
    );
        logic [1:0] idx;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4to1.sv
// XLEN-wide 4:1 data selector.
// Pure combinational; driven by the arbiter's registered sel.
module mux4to1 #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] d0,
    input  logic [XLEN-1:0] d1,
    input  logic [XLEN-1:0] d2,
    input  logic [XLEN-1:0] d3,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = d0;
        unique case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin burst arbiter with a 4:1 data mux.
// Grants last until final beat, MAX_BURST beats, or request drop.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [3:0]      last,
    input  logic [XLEN-1:0] din0,
    input  logic [XLEN-1:0] din1,
    input  logic [XLEN-1:0] din2,
    input  logic [XLEN-1:0] din3,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic            busy
);

    localparam logic [3:0] BURST = 4'(MAX_BURST);

    state_t     state, state_n;
    logic [1:0] sel_q, sel_n;
    logic [1:0] ptr_q, ptr_n;
    logic [3:0] cnt_q, cnt_n;
    logic       xfer;
    logic       rel;

    assign busy      = (state == GRANT);
    assign out_valid = busy & req[sel_q];
    assign xfer      = out_valid & out_ready;
    assign sel       = sel_q;
    assign gnt       = busy ? (4'b0001 << sel_q) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel_q <= 2'd0;
            ptr_q <= 2'd0;
            cnt_q <= 4'd0;
        end else begin
            state <= state_n;
            sel_q <= sel_n;
            ptr_q <= ptr_n;
            cnt_q <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        rel     = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    sel_n   = rr_pick(req, ptr_q);
                    cnt_n   = 4'd0;
                end
            end
            GRANT: begin
                // All release causes collapse into one, so ptr steps once.
                rel = !req[sel_q]
                    || (xfer && last[sel_q])
                    || (xfer && (cnt_q + 4'd1 == BURST));
                if (rel) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                    ptr_n   = sel_q + 2'd1;
                end else if (xfer) begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
        endcase
    end

    mux4to1 #(
        .XLEN(XLEN)
    ) u_mux (
        .sel(sel_q),
        .d0 (din0),
        .d1 (din1),
        .d2 (din2),
        .d3 (din3),
        .y  (out_data)
    );

endmodule
